// File: rtl/refill_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read-shim port among cache refill requesters.
// Holds a stalled winner stable, tags AXI IDs with the requester index and routes beats back by tag.
module refill_rd_arbiter #(
    parameter int NumPorts   = 2,
    parameter int AxiIdWidth = 4,
    parameter int BlenW      = 2,
    localparam int IdxW      = (NumPorts > 1) ? $clog2(NumPorts) : 1,
    localparam int PidW      = AxiIdWidth - IdxW
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,

    input  logic [NumPorts-1:0]         req_i,
    output logic [NumPorts-1:0]         gnt_o,
    input  logic [NumPorts*64-1:0]      addr_i,
    input  logic [NumPorts*BlenW-1:0]   blen_i,
    input  logic [NumPorts*2-1:0]       size_i,
    input  logic [NumPorts*PidW-1:0]    id_i,

    output logic [NumPorts-1:0]         rvalid_o,
    output logic                        rlast_o,
    output logic [63:0]                 rdata_o,
    output logic [PidW-1:0]             rid_o,

    output logic                        rd_req_o,
    output logic [63:0]                 rd_addr_o,
    output logic [BlenW-1:0]            rd_blen_o,
    output logic [1:0]                  rd_size_o,
    output logic [AxiIdWidth-1:0]       rd_id_o,
    input  logic                        rd_gnt_i,

    input  logic                        rd_valid_i,
    input  logic                        rd_last_i,
    input  logic [63:0]                 rd_data_i,
    input  logic [AxiIdWidth-1:0]       rd_id_i,

    output logic                        busy_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       sel_q, sel_d;
    logic [IdxW-1:0]       rr_q, rr_d;
    logic [NumPorts-1:0]   pending_q, pending_d;
    logic                  lock_q;

    logic [63:0]           addr_a [NumPorts];
    logic [BlenW-1:0]      blen_a [NumPorts];
    logic [1:0]            size_a [NumPorts];
    logic [PidW-1:0]       id_a   [NumPorts];

    logic [NumPorts-1:0]   eligible;
    logic                  any_elig;
    logic [IdxW-1:0]       win_idle;
    logic [IdxW-1:0]       winner;
    logic                  gnt;
    int                    cand;

    logic [IdxW-1:0]       rsp_idx;
    logic                  rsp_ok;

    for (genvar p = 0; p < NumPorts; p++) begin : g_unpack
        assign addr_a[p] = addr_i[p*64 +: 64];
        assign blen_a[p] = blen_i[p*BlenW +: BlenW];
        assign size_a[p] = size_i[p*2 +: 2];
        assign id_a[p]   = id_i[p*PidW +: PidW];
    end

    assign lock_q   = (state_q == ST_LOCKED);
    assign eligible = req_i & ~pending_q;

    // Round-robin search starting just after the last granted port.
    always_comb begin
        win_idle = '0;
        any_elig = 1'b0;
        cand     = 0;
        for (int i = 1; i <= NumPorts; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= NumPorts) begin
                cand = cand - NumPorts;
            end
            if (!any_elig && eligible[IdxW'(cand)]) begin
                any_elig = 1'b1;
                win_idle = IdxW'(cand);
            end
        end
    end

    assign rsp_idx = rd_id_i[AxiIdWidth-1 -: IdxW];
    assign rsp_ok  = ({1'b0, rsp_idx} < (IdxW+1)'(NumPorts));

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_d      = rr_q;
        pending_d = pending_q;
        winner    = win_idle;
        rd_req_o  = any_elig;
        gnt_o     = '0;

        if (state_q == ST_LOCKED) begin
            winner   = sel_q;
            rd_req_o = req_i[sel_q];
        end

        gnt           = rd_req_o & rd_gnt_i;
        gnt_o[winner] = gnt;

        if (rsp_ok && rd_valid_i && rd_last_i) begin
            pending_d[rsp_idx] = 1'b0;
        end

        // A locked requester that drops its request falls back to IDLE without a grant.
        if (gnt) begin
            pending_d[winner] = 1'b1;
            rr_d              = winner;
            state_d           = ST_IDLE;
        end else if (state_q == ST_IDLE && rd_req_o) begin
            sel_d   = winner;
            state_d = ST_LOCKED;
        end else if (state_q == ST_LOCKED && !rd_req_o) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            rr_q      <= IdxW'(NumPorts - 1);
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rr_q      <= rr_d;
            pending_q <= pending_d;
        end
    end

    assign rd_addr_o = addr_a[winner];
    assign rd_blen_o = blen_a[winner];
    assign rd_size_o = size_a[winner];
    assign rd_id_o   = {winner, id_a[winner]};

    always_comb begin
        rvalid_o = '0;
        if (rsp_ok) begin
            rvalid_o[rsp_idx] = rd_valid_i;
        end
    end

    assign rlast_o = rd_last_i;
    assign rdata_o = rd_data_i;
    assign rid_o   = rd_id_i[PidW-1:0];

    assign busy_o  = (|pending_q) | lock_q;

endmodule

// File: tb/tb_refill_rd_arbiter.sv
// Directed bench for refill_rd_arbiter with two ports and a 4-bit AXI ID.
module tb_refill_rd_arbiter;

    localparam int NumPorts   = 2;
    localparam int AxiIdWidth = 4;
    localparam int BlenW      = 2;
    localparam int PidW       = 3;

    logic                       clk_i = 1'b0;
    logic                       rst_ni;
    logic [NumPorts-1:0]        req_i;
    logic [NumPorts-1:0]        gnt_o;
    logic [NumPorts*64-1:0]     addr_i;
    logic [NumPorts*BlenW-1:0]  blen_i;
    logic [NumPorts*2-1:0]      size_i;
    logic [NumPorts*PidW-1:0]   id_i;
    logic [NumPorts-1:0]        rvalid_o;
    logic                       rlast_o;
    logic [63:0]                rdata_o;
    logic [PidW-1:0]            rid_o;
    logic                       rd_req_o;
    logic [63:0]                rd_addr_o;
    logic [BlenW-1:0]           rd_blen_o;
    logic [1:0]                 rd_size_o;
    logic [AxiIdWidth-1:0]      rd_id_o;
    logic                       rd_gnt_i;
    logic                       rd_valid_i;
    logic                       rd_last_i;
    logic [63:0]                rd_data_i;
    logic [AxiIdWidth-1:0]      rd_id_i;
    logic                       busy_o;

    int n_cmp = 0;
    int n_err = 0;

    refill_rd_arbiter #(
        .NumPorts   (NumPorts),
        .AxiIdWidth (AxiIdWidth),
        .BlenW      (BlenW)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .addr_i     (addr_i),
        .blen_i     (blen_i),
        .size_i     (size_i),
        .id_i       (id_i),
        .rvalid_o   (rvalid_o),
        .rlast_o    (rlast_o),
        .rdata_o    (rdata_o),
        .rid_o      (rid_o),
        .rd_req_o   (rd_req_o),
        .rd_addr_o  (rd_addr_o),
        .rd_blen_o  (rd_blen_o),
        .rd_size_o  (rd_size_o),
        .rd_id_o    (rd_id_o),
        .rd_gnt_i   (rd_gnt_i),
        .rd_valid_i (rd_valid_i),
        .rd_last_i  (rd_last_i),
        .rd_data_i  (rd_data_i),
        .rd_id_i    (rd_id_i),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic beat(input logic [3:0] id, input logic last, input logic [63:0] data);
        rd_valid_i = 1'b1;
        rd_last_i  = last;
        rd_id_i    = id;
        rd_data_i  = data;
    endtask

    task automatic no_beat();
        rd_valid_i = 1'b0;
        rd_last_i  = 1'b0;
        rd_id_i    = '0;
        rd_data_i  = '0;
    endtask

    logic [1:0] rr_exp [4];
    logic       prev_port;

    initial begin
        rst_ni   = 1'b0;
        req_i    = '0;
        addr_i   = '0;
        blen_i   = '0;
        size_i   = '0;
        id_i     = '0;
        rd_gnt_i = 1'b0;
        no_beat();
        step();
        step();
        rst_ni = 1'b1;
        #1;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_rd_req", 64'(rd_req_o), 64'd0);
        check("rst_gnt", 64'(gnt_o), 64'd0);
        check("rst_rvalid", 64'(rvalid_o), 64'd0);

        // Single request, granted immediately, two-beat burst.
        addr_i[63:0] = 64'h8000_0040;
        blen_i[1:0]  = 2'd1;
        size_i[1:0]  = 2'd3;
        id_i[2:0]    = 3'd0;
        req_i        = 2'b01;
        rd_gnt_i     = 1'b1;
        #1;
        check("single_gnt", 64'(gnt_o), 64'h1);
        check("single_rd_req", 64'(rd_req_o), 64'h1);
        check("single_rd_id", 64'(rd_id_o), 64'h0);
        check("single_addr", rd_addr_o, 64'h8000_0040);
        check("single_blen", 64'(rd_blen_o), 64'h1);
        step();
        req_i    = '0;
        rd_gnt_i = 1'b0;
        #1;
        check("single_busy", 64'(busy_o), 64'h1);
        check("single_req_off", 64'(rd_req_o), 64'h0);
        beat(4'h0, 1'b0, 64'h1111_2222_3333_4444);
        #1;
        check("single_b0_rvalid", 64'(rvalid_o), 64'h1);
        check("single_b0_data", rdata_o, 64'h1111_2222_3333_4444);
        step();
        check("single_busy_mid", 64'(busy_o), 64'h1);
        beat(4'h0, 1'b1, 64'h5555_6666_7777_8888);
        #1;
        check("single_b1_rvalid", 64'(rvalid_o), 64'h1);
        check("single_b1_last", 64'(rlast_o), 64'h1);
        step();
        no_beat();
        #1;
        check("single_busy_done", 64'(busy_o), 64'h0);

        // Round-robin from reset with single-beat responses.
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        prev_port = 1'b0;
        for (int c = 0; c < 4; c++) begin
            req_i    = 2'b11;
            rd_gnt_i = 1'b1;
            if (c > 0) beat({prev_port, 3'b000}, 1'b1, 64'(c));
            else no_beat();
            #1;
            check($sformatf("rr_gnt%0d", c), 64'(gnt_o), 64'(rr_exp[c]));
            prev_port = gnt_o[1];
            step();
        end
        req_i    = '0;
        rd_gnt_i = 1'b0;
        beat({prev_port, 3'b000}, 1'b1, 64'h0);
        step();
        no_beat();
        #1;
        check("rr_busy_done", 64'(busy_o), 64'h0);

        // Lock hold: port 1 stalls for three cycles while port 0 joins.
        addr_i[127:64] = 64'hA000_0100;
        blen_i[3:2]    = 2'd3;
        size_i[3:2]    = 2'd2;
        id_i[5:3]      = 3'd0;
        req_i          = 2'b10;
        rd_gnt_i       = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) req_i = 2'b11;
            #1;
            check($sformatf("lock_id%0d", c), 64'(rd_id_o), 64'h8);
            check($sformatf("lock_addr%0d", c), rd_addr_o, 64'hA000_0100);
            check($sformatf("lock_gnt%0d", c), 64'(gnt_o), 64'h0);
            step();
        end
        check("lock_busy", 64'(busy_o), 64'h1);
        rd_gnt_i = 1'b1;
        #1;
        check("lock_gnt_final", 64'(gnt_o), 64'h2);
        check("lock_blen", 64'(rd_blen_o), 64'h3);
        step();
        req_i    = '0;
        rd_gnt_i = 1'b0;
        beat(4'h8, 1'b1, 64'h0);
        #1;
        check("lock_rsp_rvalid", 64'(rvalid_o), 64'h2);
        step();
        no_beat();
        #1;
        check("lock_busy_done", 64'(busy_o), 64'h0);

        // Pending block: port 0 re-requests while its burst is outstanding.
        req_i    = 2'b01;
        rd_gnt_i = 1'b1;
        #1;
        check("pend_first_gnt", 64'(gnt_o), 64'h1);
        step();
        #1;
        check("pend_blocked_req", 64'(rd_req_o), 64'h0);
        check("pend_blocked_gnt", 64'(gnt_o), 64'h0);
        step();
        beat(4'h0, 1'b1, 64'hDEAD);
        #1;
        check("pend_lastcyc_req", 64'(rd_req_o), 64'h0);
        step();
        no_beat();
        #1;
        check("pend_after_req", 64'(rd_req_o), 64'h1);
        check("pend_after_gnt", 64'(gnt_o), 64'h1);
        step();
        req_i    = '0;
        rd_gnt_i = 1'b0;

        // Interleaved routing of non-last beats.
        beat(4'h9, 1'b0, 64'hA);
        #1;
        check("route_9_rvalid", 64'(rvalid_o), 64'h2);
        check("route_9_rid", 64'(rid_o), 64'h1);
        step();
        beat(4'h2, 1'b0, 64'hB);
        #1;
        check("route_2_rvalid", 64'(rvalid_o), 64'h1);
        check("route_2_rid", 64'(rid_o), 64'h2);
        step();
        beat(4'h0, 1'b1, 64'hC);
        step();
        no_beat();
        #1;
        check("route_busy_done", 64'(busy_o), 64'h0);

        // Reset mid-burst with port 1 pending.
        req_i    = 2'b10;
        rd_gnt_i = 1'b1;
        #1;
        check("rstmid_gnt1", 64'(gnt_o), 64'h2);
        step();
        req_i    = '0;
        rd_gnt_i = 1'b0;
        #1;
        check("rstmid_busy_pre", 64'(busy_o), 64'h1);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        #1;
        check("rstmid_busy_post", 64'(busy_o), 64'h0);
        req_i    = 2'b11;
        rd_gnt_i = 1'b1;
        #1;
        check("rstmid_next_gnt", 64'(gnt_o), 64'h1);
        step();

        // Last beat for port 0 coincides with grant to port 1.
        req_i = 2'b10;
        beat(4'h0, 1'b1, 64'h0);
        #1;
        check("simul_gnt1", 64'(gnt_o), 64'h2);
        step();
        no_beat();
        req_i = 2'b01;
        #1;
        check("simul_gnt0", 64'(gnt_o), 64'h1);
        step();
        req_i    = '0;
        rd_gnt_i = 1'b0;
        #1;
        check("simul_busy", 64'(busy_o), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/refill_rd_arbiter.md
# refill_rd_arbiter

Shares a single AXI read-shim port (`axi_shim` rd_* channel) among `NumPorts` cache refill requesters, such as the L1I$ refill path and a second read-only client. Arbitration is round-robin. The arbiter holds a selected request stable until the shim grants it, tags each burst's AXI ID with the requester index, and routes returned beats back by that tag. It sits between the cache-side request/ack logic and `axi_shim`. Each requester may have at most one burst outstanding.

## Interface
- `NumPorts`, default 2: number of requesters (≥2).
- `AxiIdWidth`, default 4: shim ID width. `IdxW = $clog2(NumPorts)`. Requester ID width `PidW = AxiIdWidth-IdxW`, which must be ≥1.
- `BlenW`, default 2: burst-length field width.
- `clk_i` in 1: clock.
- `rst_ni` in 1: synchronous, active-low reset.
- `req_i` in NumPorts: per-port read request. The requester holds it until `gnt_o`.
- `gnt_o` out NumPorts: per-port grant, one-hot or zero.
- `addr_i` in NumPorts×64: per-port address.
- `blen_i` in NumPorts×BlenW: per-port burst length minus 1.
- `size_i` in NumPorts×2: per-port beat size.
- `id_i` in NumPorts×PidW: per-port transaction ID.
- `rvalid_o` in NumPorts: per-port beat valid. Direction is out.
- `rlast_o` out 1: last beat, broadcast to all ports.
- `rdata_o` out 64: beat data, broadcast.
- `rid_o` out PidW: returned requester ID, with the index bits stripped.
- `rd_req_o`, `rd_addr_o`, `rd_blen_o`, `rd_size_o`, `rd_id_o` (AxiIdWidth wide) out: shim request.
- `rd_gnt_i` in 1: shim grant.
- `rd_valid_i`, `rd_last_i`, `rd_data_i` (64 wide), `rd_id_i` (AxiIdWidth wide) in: shim response.
- `busy_o` out 1: some burst is outstanding or a request is locked.

## Operation
- **Eligible port.** Port p is eligible when `req_i[p]` is high and `pending_q[p]` is 0.
- **States.**
  - IDLE: `lock_q` = 0. The winner is the first eligible port searching from `rr_q+1` modulo NumPorts. `rd_req_o` = 1 if any port is eligible.
  - LOCKED: `lock_q` = 1. The winner is `sel_q` regardless of other requests. `rd_req_o` = `req_i[sel_q]`.
- **Downstream fields.** `rd_addr_o`, `rd_blen_o` and `rd_size_o` are taken from the winner. `rd_id_o` = {winner index, `id_i[winner]`}, with the index in the MSBs.
- **Grant.** `gnt_o[winner]` = `rd_req_o & rd_gnt_i`, combinational. All other grant bits are 0.
- **On grant (clock edge):** set `pending_q[winner]`, set `rr_q` to the winner, clear `lock_q`, and go to IDLE.
- **IDLE to LOCKED.** When `rd_req_o` is high and `rd_gnt_i` is low: set `sel_q` to the winner and `lock_q` to 1. This keeps address, ID and length stable across the AXI stall.
- **LOCKED with dropped request.** If `req_i[sel_q]` drops while LOCKED (a protocol violation), clear `lock_q` with no grant and return to IDLE.
- **Response routing.**
  - Port index `k` = `rd_id_i[AxiIdWidth-1 -: IdxW]`.
  - `rvalid_o[k]` = `rd_valid_i`. All other `rvalid_o` bits are 0.
  - `rlast_o` = `rd_last_i`, `rdata_o` = `rd_data_i`, `rid_o` = low PidW bits of `rd_id_i`.
  - A beat with `k` ≥ NumPorts is dropped.
- **Burst completion.** `rd_valid_i & rd_last_i` clears `pending_q[k]`.
- **Simultaneous last beat and grant.** If a last beat for port k and a grant to port j≠k occur in the same cycle, both updates apply.
- **`busy_o`** = `|pending_q | lock_q`.

## Timing
- **Reset values** (synchronous, `rst_ni` = 0 at an edge):
  - `pending_q` = 0, `lock_q` = 0, `sel_q` = 0, `rr_q` = NumPorts-1, so port 0 has first priority.
  - All outputs are combinational from this state. With `req_i` = 0 they are 0 (`busy_o` = 0, `rd_req_o` = 0, `gnt_o` = 0).
- **Reset during a burst.** All pending state is cleared. Later beats are still routed by ID but do not change state.
- **Request path.** Zero-cycle latency from `req_i` to `rd_req_o`. The grant appears in the same cycle as `rd_gnt_i`.
- **Re-request after completion.** Port k can be re-requested downstream one cycle after the edge that captured its last beat.
- **Response path.** Response routing is purely combinational, with zero latency.
- **Stability while LOCKED.** `rd_addr_o`, `rd_id_o`, `rd_blen_o` and `rd_size_o` must not change while `rd_req_o` is high and ungranted, provided the requester holds its inputs stable.

## Test plan
- **Single request.** Port 0 requests addr 0x8000_0040, blen=1, id=0, and the shim grants in the same cycle → `gnt_o`=01, `rd_id_o`=0x0, `busy_o`=1 the next cycle. Two beats with `rd_id_i`=0x0, the second with last → `rvalid_o`=01 on both beats; `busy_o`=0 after the last beat.
- **Round-robin.** Ports 0 and 1 request continuously, and pending is cleared by immediate single-beat responses → grant order 0, 1, 0, 1, starting from reset.
- **Lock hold.** Port 1 requests while `rd_gnt_i`=0 for 3 cycles; port 0 raises `req_i` in cycle 2 → `rd_id_o`=0x8 (with AxiIdWidth=4) and addr are stable for all 3 cycles; port 1 is granted when `rd_gnt_i`=1.
- **Pending block.** Port 0 is granted and its burst is outstanding; port 0 requests again → `rd_req_o`=0 until the cycle after the last beat, then the request is granted.
- **Interleaved routing.** Beats arrive with `rd_id_i`=0x9, then 0x2 → `rvalid_o`=10 with `rid_o`=1, then `rvalid_o`=01 with `rid_o`=2.
- **Reset mid-burst.** `rst_ni`=0 for one cycle while port 1 is pending → `pending_q`=0, `busy_o`=0, and the next grant goes to port 0 when both ports request.
